// File: rtl/ysyx_210247_wb_arbiter_pkg.sv
//==============================================================================
// ysyx_210247_wb_arbiter_pkg
//   Shared widths, source-select encoding and the write-back queue entry type.
//   The pc/inst fields exist only with YSYX_210247_WB_DIFFTEST_EN.
//   Rev 1.0
//==============================================================================
`default_nettype none

package ysyx_210247_wb_arbiter_pkg;
  localparam int REG_BUS = 64;
  localparam int INST_W  = 32;
  localparam int RIDX_W  = 5;
  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

  typedef enum logic [0:0] {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [RIDX_W-1:0]  rd;
    logic [REG_BUS-1:0] data;
`ifdef YSYX_210247_WB_DIFFTEST_EN
    logic [REG_BUS-1:0] pc;
    logic [INST_W-1:0]  inst;
`endif
  } wb_entry_t;

  localparam int WB_ENTRY_W = $bits(wb_entry_t);
endpackage

`default_nettype wire

// File: rtl/ysyx_210247_wb_arbiter_if.sv
//==============================================================================
// ysyx_210247_wb_arbiter_if
//   Result handshakes, scoreboard query and regfile write port of the
//   write-back arbiter. Commit/pc/inst signals need YSYX_210247_WB_DIFFTEST_EN.
//   Rev 1.0
//==============================================================================
`default_nettype none

interface ysyx_210247_wb_arbiter_if;
  import ysyx_210247_wb_arbiter_pkg::*;

  logic               alu_valid;
  logic               alu_ready;
  logic [RIDX_W-1:0]  alu_rd;
  logic [REG_BUS-1:0] alu_data;
  logic               lsu_valid;
  logic               lsu_ready;
  logic [RIDX_W-1:0]  lsu_rd;
  logic [REG_BUS-1:0] lsu_data;
  logic               iss_valid;
  logic [RIDX_W-1:0]  iss_rd;
  logic [RIDX_W-1:0]  chk_rs1;
  logic [RIDX_W-1:0]  chk_rs2;
  logic               busy1;
  logic               busy2;
  logic               w_ena;
  logic [RIDX_W-1:0]  w_addr;
  logic [REG_BUS-1:0] w_data;
`ifdef YSYX_210247_WB_DIFFTEST_EN
  logic [REG_BUS-1:0] alu_pc;
  logic [INST_W-1:0]  alu_inst;
  logic [REG_BUS-1:0] lsu_pc;
  logic [INST_W-1:0]  lsu_inst;
  logic               cmt_valid;
  logic [REG_BUS-1:0] cmt_pc;
  logic [INST_W-1:0]  cmt_inst;
`endif

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  iss_valid, iss_rd, chk_rs1, chk_rs2,
`ifdef YSYX_210247_WB_DIFFTEST_EN
    input  alu_pc, alu_inst, lsu_pc, lsu_inst,
    output cmt_valid, cmt_pc, cmt_inst,
`endif
    output alu_ready, lsu_ready, busy1, busy2, w_ena, w_addr, w_data
  );

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output iss_valid, iss_rd, chk_rs1, chk_rs2,
`ifdef YSYX_210247_WB_DIFFTEST_EN
    output alu_pc, alu_inst, lsu_pc, lsu_inst,
    input  cmt_valid, cmt_pc, cmt_inst,
`endif
    input  alu_ready, lsu_ready, busy1, busy2, w_ena, w_addr, w_data
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_210247_wb_arbiter_fifo.sv
//==============================================================================
// ysyx_210247_wb_fifo
//   2-entry FIFO; ready comes from the registered count only.
//   Rev 1.0
//==============================================================================
`default_nettype none

module ysyx_210247_wb_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_ready,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_dout
);
  logic [WIDTH-1:0] r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_ready   = ~rst & (r_count != 2'd2);
  assign o_valid   = (r_count != 2'd0);
  assign o_dout    = r_mem[r_rptr];
  assign w_do_push = i_push & o_ready;
  assign w_do_pop  = i_pop & o_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= ~r_wptr;
      end
      if (w_do_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: rtl/ysyx_210247_wb_arbiter.sv
//==============================================================================
// ysyx_210247_wb_arbiter
//   LSU-priority write-back arbiter with RAW scoreboard; commit reporting is
//   enabled by YSYX_210247_WB_DIFFTEST_EN.
//   Rev 1.0
//==============================================================================
`default_nettype none

module ysyx_210247_wb_arbiter
  import ysyx_210247_wb_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  ysyx_210247_wb_arbiter_if.slave bus
);
  wb_entry_t          w_alu_in;
  wb_entry_t          w_lsu_in;
  wb_entry_t          w_alu_head;
  wb_entry_t          w_lsu_head;
  wb_entry_t          w_head;
  logic               w_alu_hv;
  logic               w_lsu_hv;
  logic               w_alu_pop;
  logic               w_lsu_pop;
  logic               w_pop;
  logic               w_wr;
  wb_src_e            w_sel;
  logic [31:0]        r_busy;
  logic [31:0]        w_busy_nxt;
  logic               r_w_ena;
  logic [RIDX_W-1:0]  r_w_addr;
  logic [REG_BUS-1:0] r_w_data;

  always_comb begin
    w_alu_in      = '0;
    w_lsu_in      = '0;
    w_alu_in.rd   = bus.alu_rd;
    w_alu_in.data = bus.alu_data;
    w_lsu_in.rd   = bus.lsu_rd;
    w_lsu_in.data = bus.lsu_data;
`ifdef YSYX_210247_WB_DIFFTEST_EN
    w_alu_in.pc   = bus.alu_pc;
    w_alu_in.inst = bus.alu_inst;
    w_lsu_in.pc   = bus.lsu_pc;
    w_lsu_in.inst = bus.lsu_inst;
`endif
  end

  ysyx_210247_wb_fifo #(.WIDTH(WB_ENTRY_W)) u_alu_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.alu_valid),
    .i_din   (w_alu_in),
    .o_ready (bus.alu_ready),
    .i_pop   (w_alu_pop),
    .o_valid (w_alu_hv),
    .o_dout  (w_alu_head)
  );

  ysyx_210247_wb_fifo #(.WIDTH(WB_ENTRY_W)) u_lsu_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.lsu_valid),
    .i_din   (w_lsu_in),
    .o_ready (bus.lsu_ready),
    .i_pop   (w_lsu_pop),
    .o_valid (w_lsu_hv),
    .o_dout  (w_lsu_head)
  );

  // LSU always wins: the core is stalled on an outstanding load.
  assign w_sel     = w_lsu_hv ? WB_SRC_LSU : WB_SRC_ALU;
  assign w_lsu_pop = w_lsu_hv;
  assign w_alu_pop = w_alu_hv & ~w_lsu_hv;
  assign w_pop     = w_alu_hv | w_lsu_hv;
  assign w_head    = (w_sel == WB_SRC_LSU) ? w_lsu_head : w_alu_head;
  assign w_wr      = w_pop & (w_head.rd != '0);

  // Clear before set so a re-issue in the pop cycle keeps the register busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr) begin
      w_busy_nxt[w_head.rd] = 1'b0;
    end
    if (bus.iss_valid) begin
      w_busy_nxt[bus.iss_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= '0;
      r_w_ena  <= 1'b0;
      r_w_addr <= '0;
      r_w_data <= ZERO_WORD;
    end else begin
      r_busy  <= w_busy_nxt;
      r_w_ena <= w_wr;
      if (w_wr) begin
        r_w_addr <= w_head.rd;
        r_w_data <= w_head.data;
      end
    end
  end

  assign bus.busy1  = r_busy[bus.chk_rs1];
  assign bus.busy2  = r_busy[bus.chk_rs2];
  assign bus.w_ena  = r_w_ena;
  assign bus.w_addr = r_w_addr;
  assign bus.w_data = r_w_data;

`ifdef YSYX_210247_WB_DIFFTEST_EN
  logic               r_cmt_valid;
  logic [REG_BUS-1:0] r_cmt_pc;
  logic [INST_W-1:0]  r_cmt_inst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmt_valid <= 1'b0;
      r_cmt_pc    <= ZERO_WORD;
      r_cmt_inst  <= '0;
    end else begin
      r_cmt_valid <= w_pop;
      if (w_pop) begin
        r_cmt_pc   <= w_head.pc;
        r_cmt_inst <= w_head.inst;
      end
    end
  end

  assign bus.cmt_valid = r_cmt_valid;
  assign bus.cmt_pc    = r_cmt_pc;
  assign bus.cmt_inst  = r_cmt_inst;
`endif
endmodule

`default_nettype wire
